stride_dispatch: RTL
====================

# stride_dispatch

Front end of the 4-bit-trie lookup pipeline, sitting directly upstream of the chain of `stride_find` stages. Accepts IPv4 destination addresses with a tag over a valid/ready handshake and buffers them in a FIFO. Issues at most one lookup per cycle, splitting each address into eight 4-bit strides, skewed so that stride k reaches stage k in the cycle that stage consumes it. Also provides the root block address, default-nexthop seed, and a tag/valid delay line aligned with the final stage's `nexthop_out`.

## Interface
- `STAGES`, 8: number of `stride_find` stages; must equal ADDR_WIDTH/4.
- `ADDR_WIDTH`, 32: lookup address width.
- `TAG_WIDTH`, 8: opaque query tag width.
- `FIFO_DEPTH`, 16: input buffer entries; power of two, ≥2.
- `STAGE_LAT`, 1: cycles from a stage's stride input to its registered outputs; legal range 1..4.
- `DEFAULT_NEXTHOP`, 8'h00: nexthop seed when no prefix matches.
- `ROOT_ADDR_W`, 7: width of stage-0 `search_addr`.
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  request present.
- `in_ready`  out  1  FIFO can accept.
- `in_addr`  in  ADDR_WIDTH  destination address.
- `in_tag`  in  TAG_WIDTH  query tag.
- `issue_en`  in  1  throttle; issuing is allowed only while 1.
- `stride_bus`  out  4*STAGES  slice k (bits 4k+3:4k) feeds stage k.
- `root_addr`  out  ROOT_ADDR_W  stage-0 `search_addr`; constant 0.
- `nexthop_seed`  out  8  stage-0 `nexthop_in`.
- `issue_valid`  out  1  a lookup entered stage 0 this cycle.
- `done_valid`  out  1  final-stage nexthop belongs to a real query.
- `done_tag`  out  TAG_WIDTH  tag of that query.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  current occupancy.
- `issued_total`  out  32  wrapping count of issued lookups.

## Operation
- Accept: a request is accepted on a posedge with `in_valid && in_ready`, and `{in_addr, in_tag}` is pushed.
- `in_ready` = (`fifo_count` < FIFO_DEPTH), registered-count based. There is no bypass: when the FIFO is full, `in_ready` = 0 even if a pop happens in the same cycle.
- Pop/issue: on a posedge with FIFO non-empty and `issue_en` = 1, the head is popped and launched. An entry pushed at edge A is poppable at edge A+1 at the earliest.
- Stride order: stage k receives nibble `addr[ADDR_WIDTH-1-4k -: 4]`, so stage 0 gets the MSB nibble.
- Skew: slice k is driven by a k*STAGE_LAT-deep register chain. Slice 0 is registered once at pop.
- Bubbles: a cycle without a pop shifts zeros into slice 0 and marks that slot invalid. Stride data is still consumed by the stages, but the slot never raises `done_valid`.
- Alignment: `issue_valid` and the tag enter a STAGES*STAGE_LAT-deep valid/tag delay line. `done_valid`/`done_tag` therefore emerge in the cycle the last stage presents that query's `nexthop_out`.
- Push and pop on the same edge: `fifo_count` is unchanged and both operations take effect.
- `nexthop_seed` = DEFAULT_NEXTHOP and `root_addr` = 0, both constant.
- `issued_total` increments by 1 per pop and wraps from 2^32-1 to 0.

## Timing
- Reset (`rst` = 0 at a posedge) clears:
  - FIFO pointers and `fifo_count` to 0;
  - `in_ready` to 1 from the first cycle after release;
  - all skew and delay registers, so `stride_bus` = 0, `issue_valid` = 0, `done_valid` = 0, `done_tag` = 0;
  - `issued_total` to 0.
- Reset mid-operation discards all buffered and in-flight queries; no `done_valid` is produced for them.
- Minimum latency, accept edge A to slice 0 valid: after edge A+1 (2 edges).
- `done_valid` asserts STAGES*STAGE_LAT cycles after `issue_valid`.
- Sustained throughput: 1 lookup/cycle while `issue_en` = 1 and the FIFO is non-empty.
- `issue_en` low pauses popping only. In-flight queries keep shifting and complete normally.

## Structure
- Shared package `trie_pkg`: `STRIDE_W` = 4, `NEXTHOP_W` = 8, the default `STAGES`/`ADDR_WIDTH`, and a function returning the nibble for stage k.
- Sub-module `lookup_fifo`: synchronous FIFO with registered count and no bypass, parameterized on width and depth.
- The skew chains and the tag/valid delay line stay inline, built with generate loops.

## Test plan
- Single query, STAGE_LAT = 1: addr 32'hC0A8_0A01, tag 8'h5A.
  - Slice k shows nibbles C,0,A,8,0,A,0,1 in consecutive cycles after pop.
  - `done_valid`/`done_tag` = 5A appears 8 cycles after `issue_valid`.
- Back-to-back: 20 queries streamed with tags 0..19.
  - FIFO fills to 16 and `in_ready` drops.
  - `done_tag` sequence is 0..19, contiguous, one per cycle.
  - `issued_total` = 20.
- Throttle: `issue_en` = 0 for 5 cycles mid-stream.
  - `issue_valid` shows a 5-cycle gap and `done_valid` shows the same gap 8 cycles later.
  - No tags are lost or reordered.
- Full with simultaneous pop: count = 16 with `in_valid` = 1.
  - `in_ready` = 0 and count stays 16 until a pop.
  - After the pop, `in_ready` = 1 and the next push is accepted.
- Reset mid-flight: `rst` = 0 for one cycle while 3 queries are in flight and 4 are buffered.
  - All outputs return to reset values and `fifo_count` = 0.
  - None of the 7 tags appears on `done_tag`.
- STAGE_LAT = 2: single query.
  - Slice k changes 2k cycles after pop.
  - `done_valid` asserts 16 cycles after `issue_valid`.

Source files
------------

// File: rtl/trie_pkg.sv
// Shared constants and helpers for the 4-bit-trie lookup pipeline.
// Imported by the dispatcher and the stride_find stages.
package trie_pkg;

    localparam int STRIDE_W   = 4;
    localparam int NEXTHOP_W  = 8;
    localparam int DEF_STAGES = 8;
    localparam int DEF_ADDR_W = 32;

    // Stage k consumes the k-th nibble counted from the MSB end.
    function automatic logic [STRIDE_W-1:0] stride_nibble(
        input logic [63:0] addr,
        input int          aw,
        input int          k
    );
        return STRIDE_W'(addr >> (aw - STRIDE_W * (k + 1)));
    endfunction

endpackage

// File: rtl/lookup_fifo.sv
// Synchronous FIFO with a registered occupancy count.
// Full/empty come from the count only, so there is no same-cycle bypass.
module lookup_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stride_dispatch.sv
// Trie lookup front end: buffers queries, issues one per cycle and
// skews the address strides so each stage sees its nibble on time.
module stride_dispatch
    import trie_pkg::*;
#(
    parameter int                   STAGES          = DEF_STAGES,
    parameter int                   ADDR_WIDTH      = DEF_ADDR_W,
    parameter int                   TAG_WIDTH       = 8,
    parameter int                   FIFO_DEPTH      = 16,
    parameter int                   STAGE_LAT       = 1,
    parameter logic [NEXTHOP_W-1:0] DEFAULT_NEXTHOP = 8'h00,
    parameter int                   ROOT_ADDR_W     = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    input  logic                          issue_en,
    output logic [STRIDE_W*STAGES-1:0]    stride_bus,
    output logic [ROOT_ADDR_W-1:0]        root_addr,
    output logic [NEXTHOP_W-1:0]          nexthop_seed,
    output logic                          issue_valid,
    output logic                          done_valid,
    output logic [TAG_WIDTH-1:0]          done_tag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   issued_total
);

    localparam int EW = ADDR_WIDTH + TAG_WIDTH;
    localparam int DL = STAGES * STAGE_LAT;

    logic [EW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic                  full;
    logic                  empty;
    logic                  pop;

    assign in_ready     = !full;
    assign pop          = issue_en && !empty;
    assign head_addr    = head[EW-1 -: ADDR_WIDTH];
    assign head_tag     = head[TAG_WIDTH-1:0];
    assign root_addr    = '0;
    assign nexthop_seed = DEFAULT_NEXTHOP;

    lookup_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata ({in_addr, in_tag}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Slice k: one launch register plus k*STAGE_LAT skew registers.
    for (genvar k = 0; k < STAGES; k++) begin : g_skew
        localparam int D = k * STAGE_LAT;
        logic [STRIDE_W-1:0] pipe [0:D];

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i <= D; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= pop ? stride_nibble(64'(head_addr), ADDR_WIDTH, k)
                               : '0;
                for (int i = 1; i <= D; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign stride_bus[STRIDE_W*k +: STRIDE_W] = pipe[D];
    end

    logic [DL:0]          vld;
    logic [TAG_WIDTH-1:0] tagd [0:DL];

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i <= DL; i++) begin
                tagd[i] <= '0;
            end
        end else begin
            vld     <= {vld[DL-1:0], pop};
            tagd[0] <= pop ? head_tag : '0;
            for (int i = 1; i <= DL; i++) begin
                tagd[i] <= tagd[i-1];
            end
        end
    end

    assign issue_valid = vld[0];
    assign done_valid  = vld[DL];
    assign done_tag    = tagd[DL];

    always_ff @(posedge clk) begin
        if (!rst) begin
            issued_total <= '0;
        end else if (pop) begin
            issued_total <= issued_total + 32'd1;
        end
    end

endmodule
